// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing for the five-stage core: stall, squash, memory-wait freeze,
// HLT drain, and registered EX-stage forwarding selects.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_hlt,
  input  logic [3:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [3:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic       br_taken,
  input  logic       dm_busy,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       id_ex_we,
  output logic       ex_mem_we,
  output logic       mem_wb_we,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       hlt
);

  localparam int CW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load_use;
  logic [1:0]    fwd_a_next;
  logic [1:0]    fwd_b_next;

  assign load_use = ex_mem_read && ex_reg_write && (ex_rd != 4'd0) &&
                    ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));

  // EX_MEM result is younger than MEM_WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src,
                                         input logic [3:0] erd, input logic erw,
                                         input logic [3:0] mrd, input logic mrw);
    if (erw && (erd != 4'd0) && (src == erd))
      return 2'd1;
    else if (mrw && (mrd != 4'd0) && (src == mrd))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  assign fwd_a_next = fwd_sel(id_rs, ex_rd, ex_reg_write, mem_rd, mem_reg_write);
  assign fwd_b_next = fwd_sel(id_rt, ex_rd, ex_reg_write, mem_rd, mem_reg_write);

  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    case (state)
      IDLE: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end
      RUN, DRAIN: begin
        if (!dm_busy) begin
          id_ex_we  = 1'b1;
          ex_mem_we = 1'b1;
          mem_wb_we = 1'b1;
          if (br_taken) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (state == DRAIN || load_use || id_hlt) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      fwd_a <= 2'd0;
      fwd_b <= 2'd0;
      hlt   <= 1'b0;
    end else begin
      // Bubble into ID_EX carries no operands; a frozen ID_EX keeps its selects.
      if (id_ex_flush) begin
        fwd_a <= 2'd0;
        fwd_b <= 2'd0;
      end else if (id_ex_we) begin
        fwd_a <= fwd_a_next;
        fwd_b <= fwd_b_next;
      end
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (!dm_busy && !br_taken && !load_use && id_hlt) begin
            state <= DRAIN;
            cnt   <= CW'(DRAIN_CYC);
          end
        end
        DRAIN: begin
          if (!dm_busy) begin
            if (br_taken) begin
              state <= RUN;
              cnt   <= '0;
            end else if (cnt <= CW'(1)) begin
              state <= HALTED;
              cnt   <= '0;
              hlt   <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed checks for pipe_hazard_ctrl: a RUN-state vector table followed by
// hand-written freeze, drain, branch-cancel and reset sequences.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_rs_used, id_rt_used, id_hlt;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, br_taken, dm_busy;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       hlt;

  int passed = 0;
  int total  = 0;

  pipe_hazard_ctrl #(.DRAIN_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_hlt(id_hlt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .br_taken(br_taken), .dm_busy(dm_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .hlt(hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rs, rt;
    logic       rsu, rtu;
    logic [3:0] exrd;
    logic       exrw, exmr;
    logic [3:0] memrd;
    logic       memrw, br, busy;
    logic [4:0] en;
    logic [2:0] fl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mkv(int rs, int rt, int rsu, int rtu, int exrd, int exrw, int exmr,
                               int memrd, int memrw, int br, int busy,
                               int en, int fl, int fa, int fb);
    vec_t v;
    v.rs = 4'(rs);  v.rt = 4'(rt);  v.rsu = 1'(rsu);  v.rtu = 1'(rtu);
    v.exrd = 4'(exrd);  v.exrw = 1'(exrw);  v.exmr = 1'(exmr);
    v.memrd = 4'(memrd);  v.memrw = 1'(memrw);  v.br = 1'(br);  v.busy = 1'(busy);
    v.en = 5'(en);  v.fl = 3'(fl);  v.fa = 2'(fa);  v.fb = 2'(fb);
    return v;
  endfunction

  function automatic logic [4:0] en_vec();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic clear_in();
    id_rs = 4'd0; id_rt = 4'd0; id_rs_used = 1'b1; id_rt_used = 1'b1; id_hlt = 1'b0;
    ex_rd = 4'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 4'd0; mem_reg_write = 1'b0; br_taken = 1'b0; dm_busy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem}
    //            rs rt su tu exrd rw mr memrd mrw br bsy  en       fl     fa fb
    vt[0]  = mkv(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5'h1f, 3'b000, 0, 0);
    vt[1]  = mkv(3, 5, 1, 1, 3, 1, 1, 0, 0, 0, 0, 5'h07, 3'b010, 0, 0); // LW R3 / ADD R4,R3,R5
    vt[2]  = mkv(3, 5, 1, 1, 0, 0, 0, 3, 1, 0, 0, 5'h1f, 3'b000, 2, 0); // load now in MEM
    vt[3]  = mkv(2, 2, 1, 1, 2, 1, 0, 0, 0, 0, 0, 5'h1f, 3'b000, 1, 1); // ADD R2 / SUB R6,R2,R2
    vt[4]  = mkv(0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0, 5'h1f, 3'b000, 0, 0); // R0 destination
    vt[5]  = mkv(9, 8, 1, 1, 9, 1, 0, 8, 1, 0, 0, 5'h1f, 3'b000, 1, 2);
    vt[6]  = mkv(6, 4, 1, 1, 6, 1, 0, 6, 1, 0, 0, 5'h1f, 3'b000, 1, 0); // EX_MEM beats MEM_WB
    vt[7]  = mkv(1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 1, 5'h00, 3'b000, 1, 0); // freeze holds fwd
    vt[8]  = mkv(1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 5'h00, 3'b000, 1, 0); // busy beats branch
    vt[9]  = mkv(1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 5'h1f, 3'b111, 0, 0); // taken branch squash
    vt[10] = mkv(3, 3, 0, 1, 3, 1, 1, 0, 0, 0, 0, 5'h07, 3'b010, 0, 0); // load-use via rt only
    vt[11] = mkv(3, 5, 0, 0, 3, 1, 1, 0, 0, 0, 0, 5'h1f, 3'b000, 1, 0); // sources unused: no stall
    vt[12] = mkv(3, 3, 1, 1, 3, 1, 1, 0, 0, 1, 0, 5'h1f, 3'b111, 0, 0); // branch beats load-use
    vt[13] = mkv(3, 5, 1, 1, 3, 0, 1, 0, 0, 0, 0, 5'h1f, 3'b000, 0, 0); // load without reg_write

    clear_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_en", 8'(en_vec()), 8'h00);
    chk("rst_fl", 8'(fl_vec()), 8'h07);
    chk("rst_fwd", {4'd0, fwd_a, fwd_b}, 8'h00);
    chk("rst_hlt", 8'(hlt), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_en", 8'(en_vec()), 8'h00);
    chk("idle_fl", 8'(fl_vec()), 8'h07);
    @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      id_rs = vt[i].rs; id_rt = vt[i].rt; id_rs_used = vt[i].rsu; id_rt_used = vt[i].rtu;
      id_hlt = 1'b0; ex_rd = vt[i].exrd; ex_reg_write = vt[i].exrw; ex_mem_read = vt[i].exmr;
      mem_rd = vt[i].memrd; mem_reg_write = vt[i].memrw;
      br_taken = vt[i].br; dm_busy = vt[i].busy;
      #1;
      chk($sformatf("v%0d_en", i), 8'(en_vec()), 8'(vt[i].en));
      chk($sformatf("v%0d_fl", i), 8'(fl_vec()), 8'(vt[i].fl));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_fwd", i), {4'd0, fwd_a, fwd_b}, {4'd0, vt[i].fa, vt[i].fb});
      $display("vec %0d: en=%b fl=%b fwd_a=%0d fwd_b=%0d", i, en_vec(), fl_vec(), fwd_a, fwd_b);
    end

    // Four-cycle memory wait with a known forwarding select in flight.
    @(negedge clk);
    clear_in();
    id_rs = 4'd2; ex_rd = 4'd2; ex_reg_write = 1'b1;
    @(posedge clk); #1;
    chk("busy_pre_fa", 8'(fwd_a), 8'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clear_in();
      id_rs = 4'd5; mem_rd = 4'd5; mem_reg_write = 1'b1; dm_busy = 1'b1;
      #1;
      chk($sformatf("busy%0d_en", k), 8'(en_vec()), 8'h00);
      chk($sformatf("busy%0d_fl", k), 8'(fl_vec()), 8'h00);
      @(posedge clk); #1;
      chk($sformatf("busy%0d_fa", k), 8'(fwd_a), 8'd1);
      $display("busy cycle %0d: en=%b fwd_a=%0d", k, en_vec(), fwd_a);
    end
    @(negedge clk);
    dm_busy = 1'b0;
    #1;
    chk("busy_resume_en", 8'(en_vec()), 8'h1f);
    @(posedge clk); #1;
    chk("busy_resume_fa", 8'(fwd_a), 8'd2);

    // Plain HLT: hlt rises on the fourth edge after HLT is seen in ID.
    @(negedge clk);
    clear_in();
    id_hlt = 1'b1;
    #1;
    chk("hlt0_en", 8'(en_vec()), 8'h07);
    chk("hlt0_fl", 8'(fl_vec()), 8'h02);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("drain%0d_en", k), 8'(en_vec()), 8'h07);
      chk($sformatf("drain%0d_fl", k), 8'(fl_vec()), 8'h02);
      chk($sformatf("drain%0d_hlt", k), 8'(hlt), 8'd0);
      $display("drain cycle %0d: en=%b hlt=%0d", k, en_vec(), hlt);
      @(posedge clk);
    end
    #1;
    chk("halted_hlt", 8'(hlt), 8'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      br_taken = 1'(k & 1); id_hlt = 1'b0;
      #1;
      chk($sformatf("halted%0d_en", k), 8'(en_vec()), 8'h00);
      chk($sformatf("halted%0d_fl", k), 8'(fl_vec()), 8'h00);
      chk($sformatf("halted%0d_hlt", k), 8'(hlt), 8'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_hlt", 8'(hlt), 8'd0);
    chk("halt_rst_fl", 8'(fl_vec()), 8'h07);
    @(negedge clk);
    clear_in();
    rst_n = 1'b1;
    @(posedge clk);

    // HLT drain with one busy cycle: counter holds, still four non-busy edges.
    @(negedge clk);
    id_hlt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    dm_busy = 1'b1;
    #1;
    chk("dbusy_en", 8'(en_vec()), 8'h00);
    @(posedge clk);
    @(negedge clk);
    dm_busy = 1'b0;
    @(posedge clk); #1;
    chk("dbusy_hlt_early", 8'(hlt), 8'd0);
    @(posedge clk); #1;
    chk("dbusy_hlt", 8'(hlt), 8'd1);
    $display("drain with busy: hlt=%0d", hlt);
    do_reset();

    // Older taken branch cancels the drain.
    @(negedge clk);
    clear_in();
    id_hlt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    br_taken = 1'b1;
    #1;
    chk("cancel_en", 8'(en_vec()), 8'h1f);
    chk("cancel_fl", 8'(fl_vec()), 8'h07);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      br_taken = 1'b0; id_hlt = 1'b0;
      #1;
      chk($sformatf("cancel%0d_en", k), 8'(en_vec()), 8'h1f);
      @(posedge clk); #1;
      chk($sformatf("cancel%0d_hlt", k), 8'(hlt), 8'd0);
    end
    $display("branch cancel: hlt=%0d", hlt);

    // Asynchronous reset mid-stall and mid-drain.
    @(negedge clk);
    clear_in();
    id_rs = 4'd4; ex_rd = 4'd4; ex_reg_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dm_busy = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_fa", 8'(fwd_a), 8'd0);
    chk("arst_fl", 8'(fl_vec()), 8'h07);
    @(negedge clk);
    clear_in();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    id_hlt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_drain_en", 8'(en_vec()), 8'h00);
    chk("arst_drain_fl", 8'(fl_vec()), 8'h07);
    @(negedge clk);
    clear_in();
    rst_n = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("post_arst%0d_en", k), 8'(en_vec()), 8'h1f);
      @(posedge clk); #1;
      chk($sformatf("post_arst%0d_hlt", k), 8'(hlt), 8'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
